// File: rtl/nicotb_evt_pkg.sv
// Shared types for the Nicotb event queue: edge modes, channel states, helpers.
package nicotb_evt_pkg;

  typedef enum logic [1:0] {
    MODE_OFF = 2'b00,
    MODE_POS = 2'b01,
    MODE_NEG = 2'b10,
    MODE_ANY = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_DELAY = 2'd1,
    CH_PEND  = 2'd2
  } ch_state_e;

  // Channel index width, never narrower than one bit.
  function automatic int ch_idx_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic logic edge_sel(input mode_e m, input logic pos, input logic neg);
    case (m)
      MODE_POS: return pos;
      MODE_NEG: return neg;
      MODE_ANY: return pos | neg;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nicotb_evt_fifo.sv
// DEPTH-entry synchronous FIFO; a push into a full FIFO is taken when a pop frees a slot the same cycle.
module nicotb_evt_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          rdy_i,
  output logic          can_push_o,
  output logic          valid_o,
  output logic [W-1:0]  dout_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop     = (level_q != '0) && rdy_i;
    can_push_o = (level_q != LW'(DEPTH)) || do_pop;
    do_push    = push_i && can_push_o;
    wr_d       = do_push ? wr_q + 1'b1 : wr_q;
    rd_d       = do_pop  ? rd_q + 1'b1 : rd_q;
    level_d    = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign valid_o = (level_q != '0);
  assign dout_o  = valid_o ? mem_q[rd_q] : '0;
  assign level_o = level_q;

endmodule

// File: rtl/nicotb_event_queue.sv
// Multi-channel edge/condition event capture with per-channel delay, round-robin
// arbitration into a timestamped FIFO drained over a valid/ready stream.
module nicotb_event_queue
  import nicotb_evt_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int DEPTH = 8,
  parameter  int TSW   = 16,
  parameter  int DLYW  = 4,
  localparam int CW    = ch_idx_w(NCH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       sig_i,
  input  logic [NCH-1:0]       cond_i,
  input  logic [2*NCH-1:0]     mode_i,
  input  logic [NCH*DLYW-1:0]  dly_i,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [CW-1:0]        evt_ch,
  output logic [TSW-1:0]       evt_ts,
  output logic [LW-1:0]        level,
  output logic                 ovf,
  input  logic                 ovf_clr
);

  typedef struct packed {
    logic [CW-1:0]  ch;
    logic [TSW-1:0] ts;
  } evt_t;

  logic [TSW-1:0]           now_q, now_d;
  logic [NCH-1:0]           sig_q, sig_d;
  logic                     arm_q, arm_d;
  logic [CW-1:0]            rr_q, rr_d;
  logic                     ovf_q, ovf_d;

  logic [NCH-1:0]           pos, neg, hit, pend, gnt, drop;
  logic [NCH-1:0][TSW-1:0]  cts;
  logic                     gnt_any, can_push;
  logic [CW-1:0]            gnt_idx;
  evt_t                     push_ent, head_ent;

  assign pos = sig_i & ~sig_q;
  assign neg = ~sig_i & sig_q;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    ch_state_e       st_q, st_d;
    logic [DLYW-1:0] cnt_q, cnt_d, dly;
    logic [TSW-1:0]  stamp_q, stamp_d;
    logic            start, drop_c;

    assign dly    = dly_i[c*DLYW +: DLYW];
    assign hit[c] = arm_q & cond_i[c] & edge_sel(mode_e'(mode_i[2*c +: 2]), pos[c], neg[c]);

    // A channel restarts when idle, or when its pending event leaves this very cycle.
    always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      stamp_d = stamp_q;
      start   = hit[c] && ((st_q == CH_IDLE) || (st_q == CH_PEND && gnt[c]));
      drop_c  = hit[c] && !start;
      case (st_q)
        CH_DELAY: begin
          if (cnt_q == DLYW'(1)) st_d = CH_PEND;
          else                   cnt_d = cnt_q - 1'b1;
        end
        CH_PEND:  if (gnt[c]) st_d = CH_IDLE;
        default:  st_d = st_q;
      endcase
      if (start) begin
        stamp_d = now_q;
        if (dly == '0) begin
          st_d = CH_PEND;
        end else begin
          st_d  = CH_DELAY;
          cnt_d = dly;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st_q    <= CH_IDLE;
        cnt_q   <= '0;
        stamp_q <= '0;
      end else begin
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        stamp_q <= stamp_d;
      end
    end

    assign pend[c] = (st_q == CH_PEND);
    assign drop[c] = drop_c;
    assign cts[c]  = stamp_q;
  end

  // Round-robin search from rr_q; nothing is granted while the FIFO cannot take it.
  always_comb begin
    logic [CW-1:0] idx;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = CW'((int'(rr_q) + i) % NCH);
      if (!gnt_any && pend[idx] && can_push) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
    push_ent.ch = gnt_idx;
    push_ent.ts = cts[gnt_idx];
  end

  always_comb begin
    now_d = now_q + 1'b1;
    sig_d = sig_i;
    arm_d = 1'b1;
    rr_d  = rr_q;
    if (gnt_any) rr_d = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    ovf_d = ovf_q;
    if (|drop)        ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      now_q <= '0;
      sig_q <= '0;
      arm_q <= 1'b0;
      rr_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      now_q <= now_d;
      sig_q <= sig_d;
      arm_q <= arm_d;
      rr_q  <= rr_d;
      ovf_q <= ovf_d;
    end
  end

  nicotb_evt_fifo #(
    .W     ($bits(evt_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (gnt_any),
    .din_i      (push_ent),
    .rdy_i      (evt_ready),
    .can_push_o (can_push),
    .valid_o    (evt_valid),
    .dout_o     (head_ent),
    .level_o    (level)
  );

  assign evt_ch = head_ent.ch;
  assign evt_ts = head_ent.ts;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_nicotb_event_queue.sv
// Directed bench: stimulus pushes expected {ch, ts} entries; a negedge monitor pops and compares.
module tb_nicotb_event_queue;

  localparam int NCH = 4, DEPTH = 8, TSW = 16, DLYW = 4, CW = 2, LW = 4;

  logic                clk = 1'b0, rst = 1'b1;
  logic [NCH-1:0]      sig_i = '0, cond_i = '0;
  logic [2*NCH-1:0]    mode_i = '0;
  logic [NCH*DLYW-1:0] dly_i = '0;
  logic                evt_ready = 1'b1, ovf_clr = 1'b0;
  logic                evt_valid, ovf;
  logic [CW-1:0]       evt_ch;
  logic [TSW-1:0]      evt_ts;
  logic [LW-1:0]       level;

  typedef struct packed {
    logic [CW-1:0]  ch;
    logic [TSW-1:0] ts;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   nvec = 0, nfail = 0, cyc = 0;

  nicotb_event_queue #(.NCH(NCH), .DEPTH(DEPTH), .TSW(TSW), .DLYW(DLYW)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_i     (sig_i),
    .cond_i    (cond_i),
    .mode_i    (mode_i),
    .dly_i     (dly_i),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_ts    (evt_ts),
    .level     (level),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; equals the "now" of the current cycle.
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && evt_valid && evt_ready) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL evt_unexpected: got ch=%0d ts=%0d, want none (cyc %0d)", evt_ch, evt_ts, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (evt_ch !== mon_e.ch || evt_ts !== mon_e.ts) begin
          nfail++;
          $display("FAIL evt: got ch=%0d ts=%0d, want ch=%0d ts=%0d (cyc %0d)",
                   evt_ch, evt_ts, mon_e.ch, mon_e.ts, cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic expect_evt(input int ch, input int ts);
    exp_t e;
    e.ch = CW'(ch);
    e.ts = TSW'(ts);
    exp_q.push_back(e);
  endtask

  task automatic cfg(input int c, input logic [1:0] m, input logic cnd, input int d);
    mode_i[2*c +: 2]      = m;
    cond_i[c]             = cnd;
    dly_i[c*DLYW +: DLYW] = DLYW'(d);
  endtask

  task automatic toggle(input int c);
    sig_i[c] = ~sig_i[c];
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || evt_valid) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ch", evt_ch, 0);
    chk("rst_ts", evt_ts, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #4 rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset release with a held-high pos-mode input must not fire.
    cfg(0, 2'b01, 1'b1, 0);
    cfg(1, 2'b10, 1'b0, 0);
    sig_i = 4'b0001;
    #2 do_reset();
    wait_until(2); sig_i[0] = 1'b0;
    wait_until(5); sig_i[0] = 1'b1; expect_evt(0, 5);
    wait_until(6); chk("lat0_pre", evt_valid, 0);
    wait_until(7); chk("lat0_valid", evt_valid, 1);
    sig_i[1] = 1'b1;

    // Falling edge gated by cond, then qualified with delay 3.
    wait_until(8);  sig_i[1] = 1'b0;
    wait_until(9);  sig_i[1] = 1'b1;
    wait_until(10); cfg(1, 2'b10, 1'b1, 3); sig_i[1] = 1'b0; expect_evt(1, 10);
    wait_until(14); chk("dly3_pre", evt_valid, 0);
    wait_until(15); chk("dly3_valid", evt_valid, 1);
    wait_empty(20);

    // Simultaneous bursts: order restarts at ch0 after the pointer wraps.
    for (int c = 0; c < NCH; c++) cfg(c, 2'b11, 1'b1, 0);
    sig_i = 4'b0000;
    do_reset();
    wait_until(3);
    sig_i = 4'b1111;
    for (int c = 0; c < NCH; c++) expect_evt(c, 3);
    wait_until(10);
    sig_i = 4'b0000;
    for (int c = 0; c < NCH; c++) expect_evt(c, 10);
    wait_empty(30);

    // Backpressure: 12 events into 8 entries, 4 left waiting in PEND.
    wait_until(19); evt_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      wait_until(20 + 2*k);
      toggle(k % 4);
      expect_evt(k % 4, 20 + 2*k);
    end
    wait_until(44);
    chk("full_level", level, 8);
    chk("full_ovf", ovf, 0);
    chk("full_valid", evt_valid, 1);
    evt_ready = 1'b1;
    wait_empty(60);
    chk("drained_level", level, 0);

    // Re-trigger during delay drops; clear works, a same-cycle drop beats clear.
    wait_until(60);
    cfg(0, 2'b00, 1'b0, 0); cfg(1, 2'b00, 1'b0, 0); cfg(3, 2'b00, 1'b0, 0);
    cfg(2, 2'b11, 1'b1, 5);
    wait_until(62); toggle(2); expect_evt(2, 62);
    wait_until(64); toggle(2);
    wait_until(65); chk("ovf_set", ovf, 1);
    wait_until(70); chk("ovf_sticky", ovf, 1); ovf_clr = 1'b1;
    wait_until(71); ovf_clr = 1'b0; chk("ovf_cleared", ovf, 0);
    wait_until(72); toggle(2); expect_evt(2, 72);
    wait_until(74); toggle(2); ovf_clr = 1'b1;
    wait_until(75); ovf_clr = 1'b0; chk("ovf_drop_wins", ovf, 1);
    wait_until(85); chk("ch2_single", exp_q.size(), 0); ovf_clr = 1'b1;
    wait_until(86); ovf_clr = 1'b0; chk("ovf_cleared2", ovf, 0);

    // Mid-burst asynchronous reset discards everything; timestamps restart.
    wait_until(88);
    for (int c = 0; c < NCH; c++) cfg(c, 2'b11, 1'b1, 0);
    evt_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_until(90 + 2*k);
      toggle(k % 4);
      expect_evt(k % 4, 90 + 2*k);
    end
    wait_until(101);
    chk("burst_level", level, 5);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", evt_valid, 0);
    chk("async_level", level, 0);
    exp_q.delete();
    evt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #4 rst = 1'b1;
    wait_until(2); toggle(0); expect_evt(0, 2);
    wait_empty(20);
    chk("final_ovf", ovf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
